// File: rtl/sd_spi_ctrl_if.sv
// CPU-side register port of the SD card SPI master: write strobes in,
// received byte and status out.
interface sd_spi_ctrl_if;
  logic [7:0] cpu_din;
  logic       wr_data;
  logic       wr_ctrl;
  logic       wr_div;
  logic [7:0] rx_data;
  logic [7:0] status;
  logic       busy;

  modport master (
    output cpu_din, wr_data, wr_ctrl, wr_div,
    input  rx_data, status, busy
  );

  modport slave (
    input  cpu_din, wr_data, wr_ctrl, wr_div,
    output rx_data, status, busy
  );
endinterface

// File: rtl/sd_spi_ctrl.sv
// Byte-wide SPI master (mode 0, MSB first) for the SD card slot, with a
// programmable half-period divider latched at the start of each transfer.
module sd_spi_ctrl #(
  parameter logic [7:0] DIV_RESET = 8'd11
) (
  input  logic         phi,
  input  logic         reset,
  sd_spi_ctrl_if.slave cpu,
  input  logic         sd_miso,
  output logic         sd_clk,
  output logic         sd_mosi,
  output logic         sd_ssel_n
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOW  = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;

  logic       miso_q_r;
  logic       ssel_r;
  logic       sd_ssel_n_r;
  logic       overrun_r;
  logic [7:0] div_r;
  logic [1:0] state_r;
  logic [2:0] bit_cnt_r;
  logic [7:0] hcnt_r;
  logic [7:0] hwork_r;
  logic [7:0] shreg_r;
  logic       rxbit_r;
  logic [7:0] rx_data_r;
  logic       busy_r;
  logic       sd_clk_r;
  logic       sd_mosi_r;
  logic [7:0] h_m1_s;

  // Half-period minus one; a divider of zero behaves like one.
  always_comb begin
    h_m1_s = 8'd0;
    if (div_r == 8'd0) begin
      h_m1_s = 8'd1;
    end else begin
      h_m1_s = div_r;
    end
  end

  // Single input flop on the asynchronous card data line.
  always_ff @(posedge phi) begin
    if (reset) begin
      miso_q_r <= 1'b1;
    end else begin
      miso_q_r <= sd_miso;
    end
  end

  // Control registers: select, divider, and the sticky overrun flag.
  always_ff @(posedge phi) begin
    if (reset) begin
      ssel_r      <= 1'b0;
      sd_ssel_n_r <= 1'b1;
      div_r       <= DIV_RESET;
      overrun_r   <= 1'b0;
    end else begin
      if (cpu.wr_div) begin
        div_r <= cpu.cpu_din;
      end
      if (cpu.wr_ctrl) begin
        ssel_r      <= cpu.cpu_din[0];
        sd_ssel_n_r <= ~cpu.cpu_din[0];
      end
      // A dropped byte must not be lost to a simultaneous clear.
      if (cpu.wr_data && busy_r) begin
        overrun_r <= 1'b1;
      end else if (cpu.wr_ctrl) begin
        overrun_r <= 1'b0;
      end
    end
  end

  // Shift engine: SCLK level sequencing, MOSI launch and MISO capture.
  always_ff @(posedge phi) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= 3'd0;
      hcnt_r    <= 8'd0;
      hwork_r   <= 8'd1;
      shreg_r   <= 8'd0;
      rxbit_r   <= 1'b1;
      rx_data_r <= 8'hFF;
      busy_r    <= 1'b0;
      sd_clk_r  <= 1'b0;
      sd_mosi_r <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cpu.wr_data) begin
            shreg_r   <= cpu.cpu_din;
            sd_mosi_r <= cpu.cpu_din[7];
            bit_cnt_r <= 3'd7;
            hcnt_r    <= h_m1_s;
            hwork_r   <= h_m1_s;
            busy_r    <= 1'b1;
            state_r   <= ST_LOW;
          end
        end
        ST_LOW: begin
          if (hcnt_r == 8'd0) begin
            sd_clk_r <= 1'b1;
            rxbit_r  <= miso_q_r;
            hcnt_r   <= hwork_r;
            state_r  <= ST_HIGH;
          end else begin
            hcnt_r <= hcnt_r - 8'd1;
          end
        end
        ST_HIGH: begin
          if (hcnt_r == 8'd0) begin
            sd_clk_r <= 1'b0;
            if (bit_cnt_r == 3'd0) begin
              rx_data_r <= {shreg_r[6:0], rxbit_r};
              sd_mosi_r <= 1'b1;
              busy_r    <= 1'b0;
              state_r   <= ST_IDLE;
            end else begin
              shreg_r   <= {shreg_r[6:0], rxbit_r};
              sd_mosi_r <= shreg_r[6];
              bit_cnt_r <= bit_cnt_r - 3'd1;
              hcnt_r    <= hwork_r;
              state_r   <= ST_LOW;
            end
          end else begin
            hcnt_r <= hcnt_r - 8'd1;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          sd_clk_r  <= 1'b0;
          sd_mosi_r <= 1'b1;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  assign sd_clk      = sd_clk_r;
  assign sd_mosi     = sd_mosi_r;
  assign sd_ssel_n   = sd_ssel_n_r;
  assign cpu.rx_data = rx_data_r;
  assign cpu.busy    = busy_r;
  assign cpu.status  = {busy_r, overrun_r, 5'b00000, ssel_r};

endmodule

// File: tb/tb_sd_spi_ctrl.sv
// Directed bench for sd_spi_ctrl: timing of SCLK levels, loopback data,
// divider coercion, overrun handling and mid-transfer reset.
module tb_sd_spi_ctrl;
  logic phi = 1'b0;
  logic reset = 1'b1;
  logic sd_miso, sd_clk, sd_mosi, sd_ssel_n;
  logic loop_en = 1'b0;
  logic miso_tie = 1'b1;
  int checks = 0;
  int failures = 0;

  int x_busy, x_rises, x_hmin, x_hmax, x_lmin, x_lmax;
  logic [7:0] x_mosi, x_mid_status;

  sd_spi_ctrl_if bus();

  assign sd_miso = loop_en ? sd_mosi : miso_tie;

  always #5 phi = ~phi;

  sd_spi_ctrl #(.DIV_RESET(8'd11)) dut (
    .phi(phi), .reset(reset), .cpu(bus),
    .sd_miso(sd_miso), .sd_clk(sd_clk), .sd_mosi(sd_mosi), .sd_ssel_n(sd_ssel_n)
  );

  task automatic note_run(input logic lvl, input int len);
    if (len > 0) begin
      if (lvl) begin
        if (len < x_hmin) x_hmin = len;
        if (len > x_hmax) x_hmax = len;
      end else begin
        if (len < x_lmin) x_lmin = len;
        if (len > x_lmax) x_lmax = len;
      end
    end
  endtask

  // which: 1 = wr_div, 2 = wr_ctrl; one-cycle strobe from negedge to negedge
  task automatic wr_reg(input int which, input logic [7:0] v);
    bus.cpu_din = v;
    if (which == 1) bus.wr_div = 1'b1;
    else bus.wr_ctrl = 1'b1;
    @(negedge phi);
    bus.wr_div = 1'b0;
    bus.wr_ctrl = 1'b0;
  endtask

  // op: 0 none, 1 wr_div=5, 2 wr_data=3C, 3 wr_data+wr_ctrl(0) at cycle 4
  task automatic run_xfer(input logic [7:0] tx, input int op);
    logic cur, prev;
    int run;
    x_busy = 0; x_rises = 0; x_hmin = 9999; x_hmax = 0; x_lmin = 9999; x_lmax = 0;
    x_mosi = 8'h00; x_mid_status = 8'h00;
    cur = 1'b0; prev = 1'b0; run = 0;
    bus.cpu_din = tx;
    bus.wr_data = 1'b1;
    for (int k = 0; k < 5000; k++) begin
      @(negedge phi);
      if (k == 0) bus.wr_data = 1'b0;
      if (op != 0 && k == 4) begin
        case (op)
          1: begin bus.cpu_din = 8'd5; bus.wr_div = 1'b1; end
          2: begin bus.cpu_din = 8'h3C; bus.wr_data = 1'b1; end
          3: begin bus.cpu_din = 8'h00; bus.wr_data = 1'b1; bus.wr_ctrl = 1'b1; end
          default: ;
        endcase
      end
      if (op != 0 && k == 5) begin
        bus.wr_div = 1'b0; bus.wr_data = 1'b0; bus.wr_ctrl = 1'b0;
        x_mid_status = bus.status;
      end
      if (!bus.busy) break;
      x_busy++;
      if (sd_clk && !prev) begin
        x_rises++;
        x_mosi = {x_mosi[6:0], sd_mosi};
      end
      prev = sd_clk;
      if (sd_clk == cur) run++;
      else begin note_run(cur, run); cur = sd_clk; run = 1; end
    end
    note_run(cur, run);
  endtask

  task automatic test_reset;
    checks++; if (sd_clk !== 1'b0) begin failures++; $display("FAIL rst_sclk got=%b exp=0", sd_clk); end
    checks++; if (sd_mosi !== 1'b1) begin failures++; $display("FAIL rst_mosi got=%b exp=1", sd_mosi); end
    checks++; if (sd_ssel_n !== 1'b1) begin failures++; $display("FAIL rst_ssel_n got=%b exp=1", sd_ssel_n); end
    checks++; if (bus.status !== 8'h00) begin failures++; $display("FAIL rst_status got=%h exp=00", bus.status); end
    checks++; if (bus.rx_data !== 8'hFF) begin failures++; $display("FAIL rst_rx got=%h exp=ff", bus.rx_data); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_slow_default;
    miso_tie = 1'b1;
    run_xfer(8'h00, 0);
    checks++; if (x_busy !== 192) begin failures++; $display("FAIL slow_busy got=%0d exp=192", x_busy); end
    checks++; if (x_hmin !== 12 || x_hmax !== 12) begin failures++; $display("FAIL slow_high got=%0d..%0d exp=12", x_hmin, x_hmax); end
    checks++; if (x_lmin !== 12 || x_lmax !== 12) begin failures++; $display("FAIL slow_low got=%0d..%0d exp=12", x_lmin, x_lmax); end
    checks++; if (x_rises !== 8) begin failures++; $display("FAIL slow_pulses got=%0d exp=8", x_rises); end
    checks++; if (x_mosi !== 8'h00) begin failures++; $display("FAIL slow_mosi got=%h exp=00", x_mosi); end
    checks++; if (bus.rx_data !== 8'hFF) begin failures++; $display("FAIL slow_rx got=%h exp=ff", bus.rx_data); end
  endtask

  task automatic test_loopback;
    wr_reg(1, 8'd1);
    wr_reg(2, 8'd1);
    checks++; if (sd_ssel_n !== 1'b0) begin failures++; $display("FAIL lb_ssel_n got=%b exp=0", sd_ssel_n); end
    loop_en = 1'b1;
    run_xfer(8'hA5, 0);
    checks++; if (x_mosi !== 8'hA5) begin failures++; $display("FAIL lb_mosi got=%h exp=a5", x_mosi); end
    checks++; if (x_rises !== 8) begin failures++; $display("FAIL lb_pulses got=%0d exp=8", x_rises); end
    checks++; if (x_hmin !== 2 || x_hmax !== 2 || x_lmin !== 2 || x_lmax !== 2) begin
      failures++; $display("FAIL lb_levels got=h%0d..%0d l%0d..%0d exp=2", x_hmin, x_hmax, x_lmin, x_lmax); end
    checks++; if (x_busy !== 32) begin failures++; $display("FAIL lb_busy got=%0d exp=32", x_busy); end
    checks++; if (bus.rx_data !== 8'hA5) begin failures++; $display("FAIL lb_rx got=%h exp=a5", bus.rx_data); end
    checks++; if (bus.status !== 8'h01) begin failures++; $display("FAIL lb_status got=%h exp=01", bus.status); end
  endtask

  task automatic test_div_zero;
    wr_reg(1, 8'd0);
    loop_en = 1'b0;
    miso_tie = 1'b0;
    run_xfer(8'hFF, 0);
    checks++; if (x_busy !== 32) begin failures++; $display("FAIL d0_busy got=%0d exp=32", x_busy); end
    checks++; if (x_hmin !== 2 || x_hmax !== 2 || x_lmin !== 2 || x_lmax !== 2) begin
      failures++; $display("FAIL d0_levels got=h%0d..%0d l%0d..%0d exp=2", x_hmin, x_hmax, x_lmin, x_lmax); end
    checks++; if (x_mosi !== 8'hFF) begin failures++; $display("FAIL d0_mosi got=%h exp=ff", x_mosi); end
    checks++; if (bus.rx_data !== 8'h00) begin failures++; $display("FAIL d0_rx got=%h exp=00", bus.rx_data); end
  endtask

  task automatic test_overrun;
    loop_en = 1'b1;
    wr_reg(2, 8'd0);
    run_xfer(8'h5A, 2);
    checks++; if (x_mid_status !== 8'hC0) begin failures++; $display("FAIL ovr_mid got=%h exp=c0", x_mid_status); end
    checks++; if (x_mosi !== 8'h5A) begin failures++; $display("FAIL ovr_mosi got=%h exp=5a", x_mosi); end
    checks++; if (bus.rx_data !== 8'h5A) begin failures++; $display("FAIL ovr_rx got=%h exp=5a", bus.rx_data); end
    checks++; if (bus.status !== 8'h40) begin failures++; $display("FAIL ovr_sticky got=%h exp=40", bus.status); end
    wr_reg(2, 8'd0);
    checks++; if (bus.status !== 8'h00) begin failures++; $display("FAIL ovr_clear got=%h exp=00", bus.status); end
    run_xfer(8'hC3, 3);
    checks++; if (x_mid_status !== 8'hC0) begin failures++; $display("FAIL ovr_setwins got=%h exp=c0", x_mid_status); end
    checks++; if (bus.rx_data !== 8'hC3) begin failures++; $display("FAIL ovr_rx2 got=%h exp=c3", bus.rx_data); end
    wr_reg(2, 8'd0);
  endtask

  task automatic test_div_change;
    wr_reg(1, 8'd1);
    run_xfer(8'h96, 1);
    checks++; if (x_mid_status !== 8'h80) begin failures++; $display("FAIL dc_mid got=%h exp=80", x_mid_status); end
    checks++; if (x_busy !== 32 || x_hmax !== 2) begin failures++; $display("FAIL dc_cur got=%0d/%0d exp=32/2", x_busy, x_hmax); end
    checks++; if (bus.rx_data !== 8'h96) begin failures++; $display("FAIL dc_rx got=%h exp=96", bus.rx_data); end
    run_xfer(8'h69, 0);
    checks++; if (x_busy !== 96) begin failures++; $display("FAIL dc_next_busy got=%0d exp=96", x_busy); end
    checks++; if (x_hmin !== 6 || x_hmax !== 6 || x_lmin !== 6 || x_lmax !== 6) begin
      failures++; $display("FAIL dc_levels got=h%0d..%0d l%0d..%0d exp=6", x_hmin, x_hmax, x_lmin, x_lmax); end
    checks++; if (bus.rx_data !== 8'h69) begin failures++; $display("FAIL dc_rx2 got=%h exp=69", bus.rx_data); end
  endtask

  task automatic test_back_to_back;
    wr_reg(1, 8'd1);
    run_xfer(8'h11, 0);
    run_xfer(8'hEE, 0);
    checks++; if (x_busy !== 32) begin failures++; $display("FAIL b2b_busy got=%0d exp=32", x_busy); end
    checks++; if (x_mosi !== 8'hEE) begin failures++; $display("FAIL b2b_mosi got=%h exp=ee", x_mosi); end
    checks++; if (bus.rx_data !== 8'hEE) begin failures++; $display("FAIL b2b_rx got=%h exp=ee", bus.rx_data); end
    checks++; if (bus.status !== 8'h00) begin failures++; $display("FAIL b2b_status got=%h exp=00", bus.status); end
  endtask

  task automatic test_reset_mid;
    int rises;
    logic prev;
    rises = 0; prev = 1'b0;
    wr_reg(2, 8'd1);
    bus.cpu_din = 8'hF0;
    bus.wr_data = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge phi);
      if (k == 0) bus.wr_data = 1'b0;
      if (sd_clk && !prev) rises++;
      prev = sd_clk;
      if (rises == 5 && sd_clk) break;
    end
    checks++; if (rises !== 5 || sd_clk !== 1'b1 || sd_ssel_n !== 1'b0) begin
      failures++; $display("FAIL rm_pre got=rises%0d sclk%b ssel_n%b exp=5/1/0", rises, sd_clk, sd_ssel_n); end
    reset = 1'b1;
    @(negedge phi);
    checks++; if (sd_clk !== 1'b0) begin failures++; $display("FAIL rm_sclk got=%b exp=0", sd_clk); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rm_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.rx_data !== 8'hFF) begin failures++; $display("FAIL rm_rx got=%h exp=ff", bus.rx_data); end
    checks++; if (sd_ssel_n !== 1'b1) begin failures++; $display("FAIL rm_ssel_n got=%b exp=1", sd_ssel_n); end
    checks++; if (bus.status !== 8'h00) begin failures++; $display("FAIL rm_status got=%h exp=00", bus.status); end
    reset = 1'b0;
    @(negedge phi);
  endtask

  initial begin
    bus.cpu_din = 8'h00;
    bus.wr_data = 1'b0;
    bus.wr_ctrl = 1'b0;
    bus.wr_div = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge phi);
    reset = 1'b0;
    test_reset;
    test_slow_default;
    test_loopback;
    test_div_zero;
    test_overrun;
    test_div_change;
    test_back_to_back;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
